multiplex_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 synchronous output multiplexer among four requesters. It drives the multiplexer's 2-bit selector and returns a one-hot grant to the winning requester. A requester holds ownership for as long as it keeps its request high, subject to an optional hold limit. The block sits directly in front of the multiplexer's selector input, on the same clock.

---
 rtl/multiplex_arbiter_if.sv | 12 +
 rtl/multiplex_arbiter.sv | 128 ++++++++++++
 tb/tb_multiplex_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/multiplex_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter
// that drives the shared 4:1 multiplexer's selector.
interface multiplex_arbiter_if;
  logic [3:0] iReq;
  logic [3:0] oGrant;
  logic [1:0] oSelector;
  logic       oBusy;
  logic       oTimeout;

  modport slave  (input  iReq, output oGrant, oSelector, oBusy, oTimeout);
  modport master (output iReq, input  oGrant, oSelector, oBusy, oTimeout);
endinterface

// File: rtl/multiplex_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 multiplexer, all outputs registered.
// Define MULTIPLEX_ARB_TIMEOUT_EN to build the HOLD_MAX forced-release counter.
module multiplex_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  multiplex_arbiter_if.slave   bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [1:0] sel_q,   sel_d;
  logic       busy_q,  busy_d;
  logic [1:0] ptr_q,   ptr_d;
  logic [7:0] cnt_q,   cnt_d;
  logic       tout_d;

  logic       win_vld;
  logic [1:0] win_idx;
  logic [1:0] probe;

  // Scan downward from pointer+3 so the closest set bit above the pointer is kept last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    probe   = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      probe = ptr_q + 2'(i);
      if (bus.iReq[probe]) begin
        win_vld = 1'b1;
        win_idx = probe;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    case (state_q)
      GRANT: begin
        if (!bus.iReq[sel_q]) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
        end
`ifdef MULTIPLEX_ARB_TIMEOUT_EN
        else if (cnt_q == HOLD_LAST) begin
          state_d = RELEASE;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          tout_d  = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        // IDLE and the one-cycle RELEASE bubble both arbitrate; selector is left alone.
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (win_vld) begin
          state_d = GRANT;
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          busy_d  = 1'b1;
          ptr_d   = win_idx + 2'd1;
          cnt_d   = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'b00;
      busy_q  <= 1'b0;
      ptr_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef MULTIPLEX_ARB_TIMEOUT_EN
  logic tout_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q  <= 8'd0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end

  assign bus.oTimeout = tout_q;
`else
  // Without the hold limit the counter is constant and HOLD_MAX has no effect.
  logic unused_hold;
  assign cnt_q        = 8'd0;
  assign unused_hold  = |{HOLD_LAST, cnt_d, tout_d};
  assign bus.oTimeout = 1'b0;
`endif

  assign bus.oGrant    = grant_q;
  assign bus.oSelector = sel_q;
  assign bus.oBusy     = busy_q;

endmodule

// File: tb/tb_multiplex_arbiter.sv
// Bench for multiplex_arbiter: directed scenarios followed by random requests,
// each cycle compared against an ownership-level reference model.
module tb_multiplex_arbiter;
  localparam int HOLD_MAX = 4;
`ifdef MULTIPLEX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic iClk;
  logic iRst_n;
  multiplex_arbiter_if bus();

  multiplex_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the mux, for how many cycles, and where the search starts.
  int m_owner;
  int m_ptr;
  int m_held;
  int m_sel;
  bit m_to;

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_sel   = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_edge(input logic [3:0] req);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner = -1;
      end else if (TO_EN && m_held == HOLD_MAX) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int cand;
        cand = (m_ptr + k) % 4;
        if (req[cand]) begin
          m_owner = cand;
          m_sel   = cand;
          m_ptr   = (cand + 1) % 4;
          m_held  = 1;
          break;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("grant",    32'(bus.oGrant),    32'(eg));
    chk("selector", 32'(bus.oSelector), 32'(m_sel));
    chk("busy",     32'(bus.oBusy),     32'(m_owner >= 0));
    chk("timeout",  32'(bus.oTimeout),  32'(m_to));
  endtask

  task automatic cyc();
    @(posedge iClk);
    model_edge(bus.iReq);
    #1;
    chk_model();
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.iReq = 4'b0000;
    iRst_n   = 1'b0;
    model_reset();
    #12;
    chk("rst_grant", 32'(bus.oGrant),    32'h0);
    chk("rst_sel",   32'(bus.oSelector), 32'h0);
    chk("rst_busy",  32'(bus.oBusy),     32'h0);
    chk("rst_to",    32'(bus.oTimeout),  32'h0);
    iRst_n = 1'b1;
    @(negedge iClk);

    // Two requesters, lowest index above pointer 0 wins.
    bus.iReq = 4'b1010;
    cyc();
    chk("first_sel", 32'(bus.oSelector), 32'd1);
    cyc();
    bus.iReq = 4'b1000;
    cyc();
    chk("bubble_grant", 32'(bus.oGrant),    32'h0);
    chk("bubble_sel",   32'(bus.oSelector), 32'd1);
    cyc();
    chk("next_grant", 32'(bus.oGrant),    32'b1000);
    chk("next_sel",   32'(bus.oSelector), 32'd3);
    bus.iReq = 4'b0000;
    cyc();
    cyc();

    // All requesting, each owner drops after three cycles of ownership.
    bus.iReq = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      cyc();
      chk("rr_order", 32'(bus.oSelector), 32'(order[g]));
      cyc();
      cyc();
      bus.iReq = 4'b1111 & ~(4'b0001 << bus.oSelector);
      cyc();
      bus.iReq = 4'b1111;
    end
    bus.iReq = 4'b0000;
    cyc();
    cyc();

    // Single requester held continuously.
    bus.iReq = 4'b0001;
    if (TO_EN) begin
      for (int c = 0; c < HOLD_MAX; c++) begin
        cyc();
        chk("hold_grant", 32'(bus.oGrant), 32'b0001);
      end
      cyc();
      chk("to_pulse", 32'(bus.oTimeout), 32'd1);
      chk("to_grant", 32'(bus.oGrant),   32'h0);
      cyc();
      chk("regrant",    32'(bus.oGrant),   32'b0001);
      chk("regrant_to", 32'(bus.oTimeout), 32'd0);
    end else begin
      for (int c = 0; c < 55; c++) begin
        cyc();
        chk("hold_grant", 32'(bus.oGrant),   32'b0001);
        chk("hold_to",    32'(bus.oTimeout), 32'd0);
      end
    end
    bus.iReq = 4'b0000;
    cyc();
    cyc();

    // Asynchronous reset while requester 2 owns the mux.
    bus.iReq = 4'b0100;
    cyc();
    chk("own2_sel", 32'(bus.oSelector), 32'd2);
    cyc();
    #2;
    iRst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_grant", 32'(bus.oGrant),    32'h0);
    chk("arst_sel",   32'(bus.oSelector), 32'h0);
    chk("arst_busy",  32'(bus.oBusy),     32'h0);
    bus.iReq = 4'b0110;
    #2;
    iRst_n = 1'b1;
    cyc();
    chk("post_rst_sel",   32'(bus.oSelector), 32'd1);
    chk("post_rst_grant", 32'(bus.oGrant),    32'b0010);

    // Random request traffic with occasional changes so long holds occur.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 3) bus.iReq = 4'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
